muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
// Iterative multiply/divide engine in the EX stage, next to the single-cycle ALU.
// Fed by the same forwarded operands (a, b) but takes 33 cycles per operation.
// Holds the architectural HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Raises busy so the hazard unit stalls MFHI/MFLO and further mul/div issue.
// PARAMETERS
// WIDTH   32   operand/HI/LO width; only 32 is supported
// ITERS   32   iteration cycles per operation; must equal WIDTH
// PORTS
// clk      in   1      rising-edge clock
// reset_n  in   1      asynchronous, active-low reset
// start    in   1      accept operation when high in IDLE (one-cycle pulse from EX)
// op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
// a        in   32     rs operand / dividend / multiplicand
// b        in   32     rt operand / divisor / multiplier
// mthi     in   1      write a into HI (IDLE only)
// mtlo     in   1      write a into LO (IDLE only)
// busy     out  1      operation in flight; start, mthi and mtlo are ignored while high
// done     out  1      one-cycle pulse; HI/LO hold the new result in this cycle
// hi       out  32     HI register
// lo       out  32     LO register
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and
//   datapath registers cleared. Deasserting reset mid-operation discards the operation.
// - States and transitions:
//   - IDLE: start=1 -> RUN. Capture op, magnitudes |a| and |b| (signed ops) or raw
//     values (unsigned ops), result sign bits, and a zero-divisor flag; cnt=0.
//   - RUN: one shift-add (mul) or one restoring subtract-shift (div) step per cycle.
//     After 32 cycles (cnt==31) -> FIX.
//   - FIX: apply sign, write HI/LO, done=1 next cycle -> IDLE.
// - Timing: start sampled at edge E0. busy=1 in the cycles after E0..E32.
//   HI/LO written at E33. In the cycle after E33: busy=0 and done=1.
//   Start-to-done latency is a constant 33 cycles for every op, including divide-by-zero.
// - MULT/MULTU: {hi,lo} = full 64-bit product; MULT negates the 64-bit magnitude
//   product when sign(a)^sign(b).
// - DIV/DIVU: lo = quotient, hi = remainder.
//   - The quotient truncates toward zero; the remainder takes the dividend's sign.
//   - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap).
// - Divide by zero (b==0, DIV or DIVU): lo=32'hFFFFFFFF, hi=a. Overrides the
//   iterative result; latency unchanged.
// - mthi/mtlo in IDLE: the register is written with a at the next edge; both may be high together.
// - start together with mthi/mtlo in IDLE: start wins and the move is dropped.
// - start/mthi/mtlo while busy: ignored with no side effects.
//   hi/lo keep their old values until E33.
// - done never asserts without a preceding accepted start. There is no back-pressure:
//   the result sits in HI/LO until overwritten.
// TESTING
// - MULT a=7, b=0xFFFFFFFD -> hi=FFFFFFFF, lo=FFFFFFEB. busy 33 cycles, done in cycle 34.
// - MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//   MULT with the same operands -> hi=0, lo=1.
// - DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//   DIVU a=7, b=2 -> lo=3, hi=1.
// - DIVU a=0x1234, b=0 -> lo=FFFFFFFF, hi=00001234 after 33 cycles.
//   DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
// - mthi a=AAAA0000 in IDLE -> hi=AAAA0000 next cycle.
//   mtlo pulsed while busy -> lo unchanged until done.
//   start pulsed while busy -> no second done.
// - Start MULT, pull reset_n low at cycle 10 -> busy, done, hi and lo go 0 immediately.
//   After release, a new DIVU 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 33-cycle multiply/divide engine owning the HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_p;
    logic               neg_r;
    logic               div0;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_hold;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign busy = (state != S_IDLE);

    // Operand magnitudes, one datapath step, and the sign/zero-divisor fixup.
    // prod holds {partial product, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        a_mag    = (!op[0] && a[WIDTH-1]) ? -a : a;
        b_mag    = (!op[0] && b[WIDTH-1]) ? -b : b;
        add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next = {add_sum, prod[WIDTH-1:1]};
        shifted  = prod[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, opnd};
        div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        prod_neg = -prod;
        quo      = prod[WIDTH-1:0];
        rem      = prod[2*WIDTH-1:WIDTH];
        fix_hi   = !is_div ? (neg_p ? prod_neg[2*WIDTH-1:WIDTH] : rem)
                 : div0    ? a_hold
                 : (neg_r ? -rem : rem);
        fix_lo   = !is_div ? (neg_p ? prod_neg[WIDTH-1:0] : quo)
                 : div0    ? {WIDTH{1'b1}}
                 : (neg_p ? -quo : quo);
    end

    // Control FSM plus datapath and HI/LO register updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            opnd   <= '0;
            a_hold <= '0;
            prod   <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_p  <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= !op[0] && a[WIDTH-1];
                        div0   <= op[1] && (b == '0);
                        opnd   <= op[1] ? b_mag : a_mag;
                        a_hold <= a;
                        prod   <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                S_RUN: begin
                    prod <= is_div ? div_next : mul_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
